// File: rtl/conv2d_ctrl_if.sv
// Memory-read and PE-array bus bundle for the conv2d controller.
// The master modport is the controller side; the slave modport is the memory/PE side.
interface conv2d_ctrl_if #(
  parameter int unsigned AWIDTH = 32,
  parameter int unsigned DWIDTH = 32
);
  logic              rd_req_valid;
  logic              rd_req_ready;
  logic [AWIDTH-1:0] rd_req_addr;
  logic              rd_resp_valid;
  logic [DWIDTH-1:0] rd_resp_data;
  logic [DWIDTH-1:0] pe_weight_data;
  logic              pe_weight_data_valid;
  logic [DWIDTH-1:0] pe_fm_data;
  logic              pe_fm_data_valid;
  logic              pe_fm_ready;
  logic              res_fire;

  modport master (
    output rd_req_valid, rd_req_addr,
    input  rd_req_ready,
    input  rd_resp_valid, rd_resp_data,
    output pe_weight_data, pe_weight_data_valid,
    output pe_fm_data, pe_fm_data_valid,
    input  pe_fm_ready, res_fire
  );

  modport slave (
    input  rd_req_valid, rd_req_addr,
    output rd_req_ready,
    output rd_resp_valid, rd_resp_data,
    input  pe_weight_data, pe_weight_data_valid,
    input  pe_fm_data, pe_fm_data_valid,
    output pe_fm_ready, res_fire
  );
endinterface

// File: rtl/conv2d_ctrl.sv
// Conv2D job controller: fetches kernel weights, streams the feature map to the PE array, waits for results.
// Optional job cycle counter enabled by defining CONV2D_CTRL_PERF_EN.
module conv2d_ctrl #(
  parameter int unsigned AWIDTH = 32,
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned WT_DIM = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [31:0]       fm_dim,
  input  logic [AWIDTH-1:0] wt_base_addr,
  input  logic [AWIDTH-1:0] fm_base_addr,
  output logic              idle,
  output logic              done,
  output logic [31:0]       cycle_cnt,
  conv2d_ctrl_if.master     bus
);

  localparam int unsigned       WT_N      = WT_DIM * WT_DIM;
  localparam logic [31:0]       WT_N32    = 32'(WT_N);
  localparam logic [AWIDTH-1:0] ADDR_STEP = AWIDTH'(4);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD_WT = 3'd1,
    S_LOAD_FM = 3'd2,
    S_DRAIN   = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t            state;
  logic [31:0]       fm_dim_q;
  logic [31:0]       fm_total_q;
  logic [AWIDTH-1:0] fm_base_q;
  logic [AWIDTH-1:0] addr_q;
  logic [31:0]       req_cnt_q;
  logic [31:0]       wt_resp_cnt_q;
  logic [31:0]       pop_cnt_q;
  logic [31:0]       res_cnt_q;
  logic [1:0]        out_q;
  logic [DWIDTH-1:0] fifo_mem [2];
  logic              wr_ptr_q;
  logic              rd_ptr_q;
  logic [1:0]        fifo_cnt_q;
  logic              req_valid_q;
  logic              wt_valid_q;
  logic [DWIDTH-1:0] wt_data_q;
  logic              fm_valid_q;
  logic [DWIDTH-1:0] fm_data_q;
  logic              idle_q;
  logic              done_q;

  logic              issue;
  logic              wt_resp;
  logic              push;
  logic              pop;
  logic              res_inc;
  logic [31:0]       req_cnt_n;
  logic [1:0]        out_n;
  logic [1:0]        cnt_n;
  logic              rd_ptr_n;
  logic [DWIDTH-1:0] head_n;
  logic              wt_last;
  logic              fm_last_pop;
  logic              fm_room;

  assign bus.rd_req_valid         = req_valid_q;
  assign bus.rd_req_addr          = addr_q;
  assign bus.pe_weight_data       = wt_data_q;
  assign bus.pe_weight_data_valid = wt_valid_q;
  assign bus.pe_fm_data           = fm_data_q;
  assign bus.pe_fm_data_valid     = fm_valid_q;
  assign idle                     = idle_q;
  assign done                     = done_q;

  // Handshake events and next-cycle FIFO/credit values
  always_comb begin
    issue       = req_valid_q & bus.rd_req_ready;
    wt_resp     = bus.rd_resp_valid && (state == S_LOAD_WT);
    push        = bus.rd_resp_valid && (state == S_LOAD_FM);
    pop         = fm_valid_q & bus.pe_fm_ready;
    res_inc     = bus.res_fire && (state != S_IDLE);
    req_cnt_n   = req_cnt_q + 32'(issue);
    out_n       = out_q + 2'(issue) - 2'(push);
    cnt_n       = fifo_cnt_q + 2'(push) - 2'(pop);
    rd_ptr_n    = rd_ptr_q ^ pop;
    // A word pushed into the slot that becomes the head is forwarded directly
    head_n      = (push && (wr_ptr_q == rd_ptr_n)) ? bus.rd_resp_data : fifo_mem[rd_ptr_n];
    wt_last     = wt_resp && (wt_resp_cnt_q == WT_N32 - 32'd1);
    fm_last_pop = pop && (pop_cnt_q == fm_total_q - 32'd1);
    fm_room     = (3'(out_n) + 3'(cnt_n)) < 3'd2;
  end

  // FSM, request issue, FIFO and PE-side output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      fm_dim_q      <= 32'd0;
      fm_total_q    <= 32'd0;
      fm_base_q     <= '0;
      addr_q        <= '0;
      req_cnt_q     <= 32'd0;
      wt_resp_cnt_q <= 32'd0;
      pop_cnt_q     <= 32'd0;
      res_cnt_q     <= 32'd0;
      out_q         <= 2'd0;
      wr_ptr_q      <= 1'b0;
      rd_ptr_q      <= 1'b0;
      fifo_cnt_q    <= 2'd0;
      req_valid_q   <= 1'b0;
      wt_valid_q    <= 1'b0;
      wt_data_q     <= '0;
      fm_valid_q    <= 1'b0;
      fm_data_q     <= '0;
      idle_q        <= 1'b1;
      done_q        <= 1'b0;
    end else begin
      done_q <= 1'b0;

      if (push) fifo_mem[wr_ptr_q] <= bus.rd_resp_data;
      wr_ptr_q   <= wr_ptr_q ^ push;
      rd_ptr_q   <= rd_ptr_n;
      fifo_cnt_q <= cnt_n;
      fm_valid_q <= (cnt_n != 2'd0);
      if (cnt_n != 2'd0) fm_data_q <= head_n;

      wt_valid_q <= wt_resp;
      if (wt_resp) wt_data_q <= bus.rd_resp_data;

      if (issue)   addr_q    <= addr_q + ADDR_STEP;
      if (res_inc) res_cnt_q <= res_cnt_q + 32'd1;
      if (pop)     pop_cnt_q <= pop_cnt_q + 32'd1;

      case (state)
        S_IDLE: begin
          if (start) begin
            state         <= S_LOAD_WT;
            idle_q        <= 1'b0;
            fm_dim_q      <= fm_dim;
            fm_total_q    <= 32'(fm_dim * fm_dim);
            fm_base_q     <= fm_base_addr;
            addr_q        <= wt_base_addr;
            req_cnt_q     <= 32'd0;
            wt_resp_cnt_q <= 32'd0;
            pop_cnt_q     <= 32'd0;
            res_cnt_q     <= 32'd0;
            out_q         <= 2'd0;
            req_valid_q   <= (WT_N32 != 32'd0);
          end
        end
        S_LOAD_WT: begin
          req_cnt_q   <= req_cnt_n;
          req_valid_q <= (req_cnt_n < WT_N32);
          if (wt_resp) wt_resp_cnt_q <= wt_resp_cnt_q + 32'd1;
          if (wt_last) begin
            if (fm_dim_q != 32'd0) begin
              state       <= S_LOAD_FM;
              addr_q      <= fm_base_q;
              req_cnt_q   <= 32'd0;
              req_valid_q <= 1'b1;
            end else begin
              state       <= S_DONE;
              done_q      <= 1'b1;
              req_valid_q <= 1'b0;
            end
          end
        end
        S_LOAD_FM: begin
          // Credits: in-flight reads plus buffered words never exceed FIFO depth
          req_cnt_q   <= req_cnt_n;
          out_q       <= out_n;
          req_valid_q <= (req_cnt_n < fm_total_q) && fm_room;
          if (fm_last_pop) begin
            state       <= S_DRAIN;
            req_valid_q <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (res_cnt_q >= fm_total_q) begin
            state  <= S_DONE;
            done_q <= 1'b1;
          end
        end
        S_DONE: begin
          state  <= S_IDLE;
          idle_q <= 1'b1;
        end
        default: begin
          state  <= S_IDLE;
          idle_q <= 1'b1;
        end
      endcase
    end
  end

`ifdef CONV2D_CTRL_PERF_EN
  logic [31:0] cyc_q;

  // Saturating busy-cycle counter, cleared on job acceptance and held while idle
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q <= 32'd0;
    end else if (state == S_IDLE) begin
      if (start) cyc_q <= 32'd0;
    end else if (cyc_q != 32'hFFFF_FFFF) begin
      cyc_q <= cyc_q + 32'd1;
    end
  end

  assign cycle_cnt = cyc_q;
`else
  assign cycle_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_conv2d_ctrl.sv
// Directed + randomized bench for conv2d_ctrl with a queue-based memory and PE reference model.
module tb_conv2d_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] fm_dim;
  logic [31:0] wt_base_addr;
  logic [31:0] fm_base_addr;
  logic        idle;
  logic        done;
  logic [31:0] cycle_cnt;

  conv2d_ctrl_if #(.AWIDTH(32), .DWIDTH(32)) bus ();

  conv2d_ctrl #(.AWIDTH(32), .DWIDTH(32), .WT_DIM(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .fm_dim       (fm_dim),
    .wt_base_addr (wt_base_addr),
    .fm_base_addr (fm_base_addr),
    .idle         (idle),
    .done         (done),
    .cycle_cnt    (cycle_cnt),
    .bus          (bus)
  );

  initial forever #5 clk = ~clk;

  localparam int WT_N = 9;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  mreq_t       mq[$];
  logic [31:0] exp_addr[$];
  logic [31:0] exp_wt[$];
  logic [31:0] exp_fm[$];
  int          lat, rdy_pct, fmrdy_pct;
  bit          fm_hold, res_auto, job_active;
  int          n_fire, fm_fired, fm_popped, wt_seen, resp_seen, res_pending, done_seen;
  int          job_c0, job_dim;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a >> 2) - 32'd63;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: record handshakes before the edge, check after it, then drive memory/PE inputs
  task automatic tick();
    bit          fire, pop, resp, wt_exp;
    logic [31:0] a, d, e;
    fire = (bus.rd_req_valid === 1'b1) && (bus.rd_req_ready === 1'b1);
    a    = bus.rd_req_addr;
    pop  = (bus.pe_fm_data_valid === 1'b1) && (bus.pe_fm_ready === 1'b1);
    d    = bus.pe_fm_data;
    resp = (bus.rd_resp_valid === 1'b1);
    wt_exp = job_active && resp && (resp_seen < WT_N);
    if (job_active && resp) resp_seen++;
    @(posedge clk);
    #1;
    cyc++;
    if (fire) begin
      n_fire++;
      if (n_fire > WT_N) fm_fired++;
      if (exp_addr.size() > 0) e = exp_addr.pop_front(); else e = ~a;
      check("req_addr", a, e);
      mq.push_back('{a, cyc + lat});
    end
    check("wt_valid", 32'(bus.pe_weight_data_valid), 32'(wt_exp));
    if (bus.pe_weight_data_valid === 1'b1) begin
      wt_seen++;
      if (exp_wt.size() > 0) e = exp_wt.pop_front(); else e = ~bus.pe_weight_data;
      check("wt_data", bus.pe_weight_data, e);
    end
    if (pop) begin
      fm_popped++;
      res_pending++;
      if (exp_fm.size() > 0) e = exp_fm.pop_front(); else e = ~d;
      check("fm_data", d, e);
    end
    if (fm_fired > 0) check("fm_inflight_le2", 32'(fm_fired - fm_popped <= 2), 32'd1);
    if (done === 1'b1) done_seen++;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      bus.rd_resp_valid = 1'b1;
      bus.rd_resp_data  = mem_word(mq[0].addr);
      void'(mq.pop_front());
    end else begin
      bus.rd_resp_valid = 1'b0;
      bus.rd_resp_data  = $urandom;
    end
    bus.rd_req_ready = ($urandom_range(99) < rdy_pct);
    bus.pe_fm_ready  = !fm_hold && ($urandom_range(99) < fmrdy_pct);
    if (res_auto) begin
      bus.res_fire = (res_pending > 0) && ($urandom_range(1) == 1);
      if (bus.res_fire) res_pending--;
    end
  endtask

  task automatic start_job(input logic [31:0] wt, input logic [31:0] fm, input int dim);
    exp_addr.delete(); exp_wt.delete(); exp_fm.delete();
    for (int k = 0; k < WT_N; k++) begin
      exp_addr.push_back(wt + 32'(4 * k));
      exp_wt.push_back(mem_word(wt + 32'(4 * k)));
    end
    for (int k = 0; k < dim * dim; k++) begin
      exp_addr.push_back(fm + 32'(4 * k));
      exp_fm.push_back(mem_word(fm + 32'(4 * k)));
    end
    n_fire = 0; fm_fired = 0; fm_popped = 0; wt_seen = 0;
    resp_seen = 0; res_pending = 0; done_seen = 0; job_dim = dim;
    wt_base_addr = wt; fm_base_addr = fm; fm_dim = 32'(dim);
    start = 1'b1;
    job_active = 1'b1;
    tick();
    start = 1'b0;
    job_c0 = cyc;
    check("busy_after_start", 32'(idle), 32'd0);
  endtask

  task automatic wait_done(input int budget);
    int          n;
    logic [31:0] exp_cc;
    n = 0;
    while (done_seen == 0 && n < budget) begin
      tick();
      n++;
    end
    check("done_seen", 32'(done_seen), 32'd1);
    tick();
    check("done_one_cycle", 32'(done), 32'd0);
    check("idle_after_done", 32'(idle), 32'd1);
`ifdef CONV2D_CTRL_PERF_EN
    exp_cc = 32'(cyc - job_c0);
`else
    exp_cc = 32'd0;
`endif
    check("cycle_cnt", cycle_cnt, exp_cc);
    check("wt_pulses", 32'(wt_seen), 32'(WT_N));
    check("fm_words", 32'(fm_popped), 32'(job_dim * job_dim));
    check("reads_issued", 32'(n_fire), 32'(WT_N + job_dim * job_dim));
    job_active = 1'b0;
  endtask

  initial begin
    int          n;
    logic [31:0] wb, fb;
    rst = 1'b1; start = 1'b0; fm_dim = 32'd0; wt_base_addr = 32'd0; fm_base_addr = 32'd0;
    bus.rd_req_ready = 1'b0; bus.rd_resp_valid = 1'b0; bus.rd_resp_data = 32'd0;
    bus.pe_fm_ready = 1'b0; bus.res_fire = 1'b0;
    lat = 0; rdy_pct = 100; fmrdy_pct = 100; fm_hold = 1'b0; res_auto = 1'b1; job_active = 1'b0;
    n_fire = 0; fm_fired = 0; fm_popped = 0; wt_seen = 0; resp_seen = 0; res_pending = 0; done_seen = 0;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_idle", 32'(idle), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_req_valid", 32'(bus.rd_req_valid), 32'd0);
    check("rst_wt_valid", 32'(bus.pe_weight_data_valid), 32'd0);
    check("rst_fm_valid", 32'(bus.pe_fm_data_valid), 32'd0);
    check("rst_wt_data", bus.pe_weight_data, 32'd0);
    check("rst_fm_data", bus.pe_fm_data, 32'd0);
    check("rst_cycle_cnt", cycle_cnt, 32'd0);

    // Weights 1..9 at 0x100, empty feature map
    start_job(32'h100, 32'h2000, 0);
    wait_done(500);

    // Single-cycle memory, small map
    start_job(32'h200, 32'h3000, 2);
    wait_done(500);

    // PE stalls for 20 cycles after weights
    fm_hold = 1'b1;
    start_job(32'h100, 32'h4000, 4);
    n = 0;
    while (wt_seen < WT_N && n < 200) begin tick(); n++; end
    repeat (20) tick();
    check("hold_reads", 32'(fm_fired), 32'd2);
    check("hold_fm_valid", 32'(bus.pe_fm_data_valid), 32'd1);
    fm_hold = 1'b0;
    wait_done(1000);

    // Start during DRAIN is ignored; done only after the 16th result
    res_auto = 1'b0;
    bus.res_fire = 1'b0;
    start_job(32'h100, 32'h5000, 4);
    n = 0;
    while (fm_popped < 16 && n < 500) begin tick(); n++; end
    fm_dim = 32'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bus.res_fire = 1'b1;
      tick();
      bus.res_fire = 1'b0;
      if (i < 15) begin
        repeat (2) begin
          tick();
          check("early_done", 32'(done), 32'd0);
        end
      end
    end
    wait_done(50);
    res_auto = 1'b1;

    // Reset mid-LOAD_FM with two reads in flight
    lat = 6; fm_hold = 1'b1;
    start_job(32'h100, 32'h6000, 3);
    n = 0;
    while (fm_fired < 2 && n < 500) begin tick(); n++; end
    check("inflight_at_rst", 32'(mq.size()), 32'd2);
    rst = 1'b1;
    job_active = 1'b0;
    tick();
    rst = 1'b0;
    exp_addr.delete(); exp_wt.delete(); exp_fm.delete();
    n_fire = 0; fm_fired = 0; fm_popped = 0;
    fm_hold = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("post_rst_idle", 32'(idle), 32'd1);
      check("post_rst_fm_valid", 32'(bus.pe_fm_data_valid), 32'd0);
      check("post_rst_req_valid", 32'(bus.rd_req_valid), 32'd0);
    end
    check("late_resp_drained", 32'(mq.size()), 32'd0);
    lat = 0;
    start_job(32'h300, 32'h7000, 2);
    wait_done(500);

    // Randomized jobs, first one wraps the weight addresses past 2^32
    for (int j = 0; j < 4; j++) begin
      lat       = $urandom_range(3);
      rdy_pct   = $urandom_range(100, 30);
      fmrdy_pct = $urandom_range(100, 30);
      wb = $urandom; wb[1:0] = 2'b00;
      fb = $urandom; fb[1:0] = 2'b00;
      if (j == 0) wb = 32'hFFFF_FFF0;
      start_job(wb, fb, $urandom_range(4, 1));
      wait_done(3000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/conv2d_ctrl.md
CONV2D_CTRL -- requirements
Module: conv2D_ctrl

Interface
REQ-001 SHALL have parameter AWIDTH, default 32, meaning read address width.
REQ-002 SHALL have parameter DWIDTH, default 32, meaning data word width.
REQ-003 SHALL have parameter WT_DIM, default 3, meaning kernel edge; weight count is WT_DIM*WT_DIM.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have ports start (input, 1, job request) and fm_dim (input, 32, feature-map edge; legal 0..65535).
REQ-007 SHALL have ports wt_base_addr and fm_base_addr (input, AWIDTH each, byte base addresses).
REQ-008 SHALL have ports idle (output, 1, FSM in IDLE) and done (output, 1, one-cycle job-complete pulse).
REQ-009 SHALL have ports rd_req_valid (output, 1), rd_req_ready (input, 1) and rd_req_addr (output, AWIDTH): memory read request.
REQ-010 SHALL have ports rd_resp_valid (input, 1) and rd_resp_data (input, DWIDTH): in-order read response, no backpressure.
REQ-011 SHALL have ports pe_weight_data (output, DWIDTH) and pe_weight_data_valid (output, 1): weight broadcast to PE array.
REQ-012 SHALL have ports pe_fm_data (output, DWIDTH), pe_fm_data_valid (output, 1) and pe_fm_ready (input, 1): feature-map stream to PE array.
REQ-013 SHALL have port res_fire (input, 1): pulse per result accepted from PE array output.
REQ-014 SHALL have port cycle_cnt (output, 32): job cycle counter (see Configuration).

Function
REQ-015 SHALL implement FSM states IDLE, LOAD_WT, LOAD_FM, DRAIN, DONE.
REQ-016 SHALL move IDLE->LOAD_WT on start; start in any other state SHALL be ignored; fm_dim and base addresses SHALL be latched at acceptance.
REQ-017 SHALL in LOAD_WT issue exactly WT_DIM*WT_DIM reads at wt_base_addr + 4*k, k=0..N-1, address arithmetic modulo 2^AWIDTH.
REQ-018 SHALL forward each weight response registered: pe_weight_data_valid high exactly one cycle, one cycle after its rd_resp_valid, in response order.
REQ-019 SHALL leave LOAD_WT after the last weight response: to LOAD_FM if latched fm_dim != 0, else directly to DONE.
REQ-020 SHALL in LOAD_FM issue exactly fm_dim*fm_dim reads at fm_base_addr + 4*k, product computed 32-bit.
REQ-021 SHALL buffer fm responses in a 2-entry FIFO; pe_fm_data_valid = FIFO non-empty; entry pops when pe_fm_valid & pe_fm_ready; simultaneous push and pop on a full FIFO SHALL be legal.
REQ-022 SHALL assert rd_req_valid only while (requests outstanding + FIFO occupancy) < 2, guaranteeing no FIFO overflow; a request is issued on rd_req_valid & rd_req_ready.
REQ-023 SHALL move LOAD_FM->DRAIN when the last fm word has been popped.
REQ-024 SHALL count res_fire pulses in all non-IDLE states; DRAIN->DONE when count reaches fm_dim*fm_dim (may already be reached on entry).
REQ-025 SHALL assert done only in DONE, for one cycle, then return to IDLE.
REQ-026 SHALL ignore rd_resp_valid and res_fire while in IDLE.
REQ-027 SHALL hold rd_req_addr stable while rd_req_valid high and rd_req_ready low.

Reset
REQ-028 SHALL on rst (any state, mid-job included) enter IDLE, empty the FIFO, clear outstanding/result counters and all address counters.
REQ-029 SHALL drive after reset: idle=1, done=0, rd_req_valid=0, pe_weight_data_valid=0, pe_fm_data_valid=0, pe_weight_data=0, pe_fm_data=0, cycle_cnt=0.

Configuration
REQ-030 SHALL, with macro CONV2D_CTRL_PERF_EN defined, clear cycle_cnt on start acceptance, increment it each cycle outside IDLE, saturate at 32'hFFFFFFFF, and hold it after DONE until next start.
REQ-031 SHALL, without CONV2D_CTRL_PERF_EN, tie cycle_cnt to 0 and contain no counter logic.

Verification
REQ-032 SHALL cover: WT_DIM=3, weights 1..9 at wt_base 0x100, zero-latency memory -> 9 weight pulses, data 1..9, addresses 0x100..0x120.
REQ-033 SHALL cover: fm_dim=4, pe_fm_ready held 0 for 20 cycles -> at most 2 reads issued, no data lost; 16 fm words delivered in order after release.
REQ-034 SHALL cover: fm_dim=0 -> 9 weight reads, no fm reads, done pulse, idle=1 next cycle.
REQ-035 SHALL cover: rst asserted mid-LOAD_FM with 2 reads outstanding, late responses arrive -> no pe_fm_data_valid, idle=1, new job runs correctly.
REQ-036 SHALL cover: start pulsed during DRAIN -> ignored; done fires only after 16 res_fire pulses (fm_dim=4).
REQ-037 SHALL cover: with CONV2D_CTRL_PERF_EN, single-cycle memory, fm_dim=2 -> cycle_cnt equals measured start-to-done cycles; without macro cycle_cnt=0.
